branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port memory_stall, input, 1: pipeline frozen; no push, pop or state change.
REQ-004 SHALL have port pred_valid, input, 1: fetch issued a control-flow instruction; push prediction.
REQ-005 SHALL have port pred_pc, input, 32: PC of the predicted instruction.
REQ-006 SHALL have port pred_taken, input, 1: fetch predicted taken.
REQ-007 SHALL have port pred_target, input, 32: predicted next PC.
REQ-008 SHALL have port ex_valid, input, 1: EX stage resolved the oldest control-flow instruction.
REQ-009 SHALL have port ex_pc, input, 32: PC of the resolved instruction.
REQ-010 SHALL have port ex_taken, input, 1: actual direction.
REQ-011 SHALL have port ex_target, input, 32: actual taken target.
REQ-012 SHALL have port flush, output, 1: squash IF/ID; one-cycle pulse.
REQ-013 SHALL have port redirect_pc, output, 32: correct fetch PC; valid while flush=1.
REQ-014 SHALL have port upd_valid, output, 1: write one predictor entry; one-cycle pulse.
REQ-015 SHALL have port upd_index, output, 3: predictor set index, ex_pc[4:2].
REQ-016 SHALL have port upd_tag, output, 3: ex_pc[7:5].
REQ-017 SHALL have port upd_target, output, 6: ex_target[7:2].
REQ-018 SHALL have port pq_full, output, 1: prediction queue full; fetch must stall.
REQ-019 SHALL have port err, output, 1: sticky protocol error.

Function
REQ-020 SHALL hold in-flight predictions {pc, taken, target} in a 4-entry FIFO: push on pred_valid, pop on ex_valid.
REQ-021 SHALL compare each pop against the head entry; mispredict = (pred_taken != ex_taken) | (ex_taken & pred_target != ex_target).
REQ-022 SHALL assert flush and redirect_pc exactly one cycle after a mispredicting ex_valid, with redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap).
REQ-023 SHALL assert upd_valid one cycle after any ex_valid with ex_taken=1 and mispredict=1; otherwise upd_valid=0.
REQ-024 SHALL use FSM states RUN and RECOVER: RUN->RECOVER on mispredict; RECOVER->RUN after exactly one cycle.
REQ-025 SHALL clear the FIFO on mispredict; pushes in the mispredict cycle and in RECOVER are discarded as wrong-path.
REQ-026 SHALL accept simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-027 SHALL pop first when a push and pop coincide while full, so the push is accepted.
REQ-028 SHALL drop a push while full without a pop and set err.
REQ-029 SHALL set err on ex_valid with an empty FIFO; no flush and no update are produced.
REQ-030 SHALL set err on ex_pc != head pc; the head is still popped and compared.
REQ-031 SHALL keep pointers and FSM unchanged while memory_stall=1, ignore pred_valid and ex_valid, and drive flush=0, upd_valid=0.
REQ-032 SHALL wrap pointers modulo 4 and track occupancy 0..4 with a 3-bit count.

Reset
REQ-033 SHALL, on rst, empty the FIFO, set state RUN, and drive flush=0, redirect_pc=0, upd_valid=0, upd_index=0, upd_tag=0, upd_target=0, pq_full=0, err=0.
REQ-034 SHALL give rst priority over all events, including mid-RECOVER and a coincident ex_valid.

Configuration
REQ-035 SHALL, when BRU_PERF_CNT_EN is defined, add 32-bit saturating outputs perf_branches (pops) and perf_mispredicts (flushes), reset to 0 and frozen under memory_stall.
REQ-036 SHALL, when BRU_PERF_CNT_EN is undefined, omit the counters and their ports; all other behaviour is identical.

Structure
REQ-037 SHALL take PQ_DEPTH=4, BTB_IDX_W=3, BTB_TAG_W=3, BTB_TGT_W=6 and the prediction-entry struct from shared package riscv_bp_pkg.
REQ-038 SHALL implement the FIFO as sub-module bru_pred_fifo (push, pop, clear, full, empty, head).

Verification
REQ-039 SHALL verify: push {0x40, taken, 0x80}, then ex {0x40, taken, 0x80} -> no flush, no upd, queue empty.
REQ-040 SHALL verify: push {0x44, not taken}, then ex {0x44, taken, 0x20} -> next cycle flush=1, redirect_pc=0x20, upd_valid=1, idx=1, tag=2, tgt=0x08.
REQ-041 SHALL verify: push {0x48, taken, 0x90}, then ex {0x48, not taken} -> flush=1, redirect_pc=0x4C, upd_valid=0; pushes during RECOVER dropped.
REQ-042 SHALL verify: 4 pushes -> pq_full=1; push+pop same cycle -> accepted, pq_full stays 1; 5th lone push -> err=1.
REQ-043 SHALL verify: memory_stall=1 with pred_valid, ex_valid -> no state change; after deassert, behaviour matches the same stimulus unstalled.
REQ-044 SHALL verify: rst asserted in the RECOVER cycle -> all outputs 0, FIFO empty, next push accepted.

Source files
------------

// File: rtl/riscv_bp_pkg.sv
// Shared branch-prediction types: queue geometry, predictor field widths,
// the in-flight prediction entry and the resolve-unit FSM states.
package riscv_bp_pkg;

   localparam int PQ_DEPTH  = 4;
   localparam int PQ_PTR_W  = 2;
   localparam int PQ_CNT_W  = 3;
   localparam int BTB_IDX_W = 3;
   localparam int BTB_TAG_W = 3;
   localparam int BTB_TGT_W = 6;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } pred_entry_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } bru_state_e;

   // Target only matters when the branch really went taken.
   function automatic logic is_mispredict(input pred_entry_t e,
                                          input logic        ex_taken,
                                          input logic [31:0] ex_target);
      return (e.taken != ex_taken) | (ex_taken & (e.target != ex_target));
   endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// Four-entry in-flight prediction queue. clear_i wins over push/pop; a push
// into a full queue is accepted only when a pop happens in the same cycle.
module bru_pred_fifo
   import riscv_bp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        clear_i,
   input  pred_entry_t push_data_i,
   output logic        full_o,
   output logic        empty_o,
   output pred_entry_t head_o
);

   pred_entry_t         mem_q [PQ_DEPTH];
   logic [PQ_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PQ_CNT_W-1:0] count_q;
   logic                do_push, do_pop;

   assign full_o  = (count_q == PQ_CNT_W'(PQ_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PQ_PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PQ_PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + PQ_CNT_W'(1);
            2'b01:   count_q <= count_q - PQ_CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted control flow against EX results: flush/redirect on a
// mispredict, predictor update on taken mispredicts. Optional perf counters
// are built when BRU_PERF_CNT_EN is defined.
//
// Handshake: pred_valid and ex_valid are single-cycle valid strobes with no
// ready; back-pressure to fetch is pq_full, and memory_stall masks both.
module branch_resolve_unit
   import riscv_bp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 memory_stall,
   input  logic                 pred_valid,
   input  logic [31:0]          pred_pc,
   input  logic                 pred_taken,
   input  logic [31:0]          pred_target,
   input  logic                 ex_valid,
   input  logic [31:0]          ex_pc,
   input  logic                 ex_taken,
   input  logic [31:0]          ex_target,
   output logic                 flush,
   output logic [31:0]          redirect_pc,
   output logic                 upd_valid,
   output logic [BTB_IDX_W-1:0] upd_index,
   output logic [BTB_TAG_W-1:0] upd_tag,
   output logic [BTB_TGT_W-1:0] upd_target,
   output logic                 pq_full,
   output bru_state_e           dbg_state,
`ifdef BRU_PERF_CNT_EN
   output logic [31:0]          perf_branches,
   output logic [31:0]          perf_mispredicts,
`endif
   output logic                 err
);

   bru_state_e           state_q, state_d;
   logic                 flush_q, flush_d;
   logic [31:0]          redirect_q, redirect_d;
   logic                 upd_valid_q, upd_valid_d;
   logic [BTB_IDX_W-1:0] upd_index_q, upd_index_d;
   logic [BTB_TAG_W-1:0] upd_tag_q, upd_tag_d;
   logic [BTB_TGT_W-1:0] upd_target_q, upd_target_d;
   logic                 err_q, err_d;

   logic        fifo_full, fifo_empty;
   pred_entry_t head, push_data;
   logic        ex_act, pred_act, pop, mispredict;
   logic        pc_err, empty_err, push_req, overflow, push;

   assign ex_act     = ex_valid & ~memory_stall;
   assign pred_act   = pred_valid & ~memory_stall;
   assign pop        = ex_act & ~fifo_empty;
   assign mispredict = pop & is_mispredict(head, ex_taken, ex_target);
   assign pc_err     = pop & (ex_pc != head.pc);
   assign empty_err  = ex_act & fifo_empty;
   // Anything fetched alongside or right after a mispredict is wrong-path.
   assign push_req   = pred_act & (state_q == ST_RUN) & ~mispredict;
   assign overflow   = push_req & fifo_full & ~pop;
   assign push       = push_req & ~overflow;
   assign push_data  = '{pc: pred_pc, taken: pred_taken, target: pred_target};

   bru_pred_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .pop_i       (pop),
      .clear_i     (mispredict),
      .push_data_i (push_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   always_comb begin
      state_d = state_q;
      if (!memory_stall) begin
         case (state_q)
            ST_RUN:     if (mispredict) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      flush_d      = flush_q;
      redirect_d   = redirect_q;
      upd_valid_d  = upd_valid_q;
      upd_index_d  = upd_index_q;
      upd_tag_d    = upd_tag_q;
      upd_target_d = upd_target_q;
      err_d        = err_q;
      if (!memory_stall) begin
         flush_d     = mispredict;
         upd_valid_d = mispredict & ex_taken;
         err_d       = err_q | overflow | empty_err | pc_err;
         if (mispredict) redirect_d = ex_taken ? ex_target : ex_pc + 32'd4;
         if (mispredict && ex_taken) begin
            upd_index_d  = ex_pc[4:2];
            upd_tag_d    = ex_pc[7:5];
            upd_target_d = ex_target[7:2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         upd_valid_q  <= 1'b0;
         upd_index_q  <= '0;
         upd_tag_q    <= '0;
         upd_target_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         upd_valid_q  <= upd_valid_d;
         upd_index_q  <= upd_index_d;
         upd_tag_q    <= upd_tag_d;
         upd_target_q <= upd_target_d;
         err_q        <= err_d;
      end
   end

   // A pulse pending when a stall begins is held and emitted after it ends.
   assign flush       = flush_q & ~memory_stall;
   assign upd_valid   = upd_valid_q & ~memory_stall;
   assign redirect_pc = redirect_q;
   assign upd_index   = upd_index_q;
   assign upd_tag     = upd_tag_q;
   assign upd_target  = upd_target_q;
   assign pq_full     = fifo_full;
   assign err         = err_q;
   assign dbg_state   = state_q;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_mp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_q <= '0;
         perf_mp_q <= '0;
      end else begin
         if (pop && perf_br_q != 32'hFFFF_FFFF)        perf_br_q <= perf_br_q + 32'd1;
         if (mispredict && perf_mp_q != 32'hFFFF_FFFF) perf_mp_q <= perf_mp_q + 32'd1;
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations for
// hit, mispredict, queue full/overflow, stall, reset and address wrap.
module tb_branch_resolve_unit;
   import riscv_bp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        memory_stall;
   logic        pred_valid, pred_taken;
   logic [31:0] pred_pc, pred_target;
   logic        ex_valid, ex_taken;
   logic [31:0] ex_pc, ex_target;
   logic        flush, upd_valid, pq_full, err;
   logic [31:0] redirect_pc;
   logic [2:0]  upd_index, upd_tag;
   logic [5:0]  upd_target;
   bru_state_e  dbg_state;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   branch_resolve_unit dut (
      .clk          (clk),
      .rst          (rst),
      .memory_stall (memory_stall),
      .pred_valid   (pred_valid),
      .pred_pc      (pred_pc),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .ex_valid     (ex_valid),
      .ex_pc        (ex_pc),
      .ex_taken     (ex_taken),
      .ex_target    (ex_target),
      .flush        (flush),
      .redirect_pc  (redirect_pc),
      .upd_valid    (upd_valid),
      .upd_index    (upd_index),
      .upd_tag      (upd_tag),
      .upd_target   (upd_target),
      .pq_full      (pq_full),
      .dbg_state    (dbg_state),
`ifdef BRU_PERF_CNT_EN
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts),
`endif
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pred_valid = 1'b0;
      ex_valid   = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      pred_valid  = 1'b1;
      pred_pc     = pc;
      pred_taken  = tk;
      pred_target = tgt;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      ex_valid  = 1'b1;
      ex_pc     = pc;
      ex_taken  = tk;
      ex_target = tgt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_flush"},  32'(flush), 32'd0);
      check_eq({pfx, "_redir"},  redirect_pc, 32'd0);
      check_eq({pfx, "_upd"},    32'(upd_valid), 32'd0);
      check_eq({pfx, "_idx"},    32'(upd_index), 32'd0);
      check_eq({pfx, "_tag"},    32'(upd_tag), 32'd0);
      check_eq({pfx, "_tgt"},    32'(upd_target), 32'd0);
      check_eq({pfx, "_full"},   32'(pq_full), 32'd0);
      check_eq({pfx, "_err"},    32'(err), 32'd0);
      check_eq({pfx, "_state"},  32'(dbg_state), 32'(ST_RUN));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; memory_stall = 1'b0;
      pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
      ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
      step(); step();
      rst = 1'b0;
      check_all_zero("reset");

      // Correct taken prediction, then the queue must be empty.
      push(32'h40, 1'b1, 32'h80); step();
      resolve(32'h40, 1'b1, 32'h80); step();
      check_eq("hit_flush", 32'(flush), 32'd0);
      check_eq("hit_upd",   32'(upd_valid), 32'd0);
      check_eq("hit_err",   32'(err), 32'd0);
      resolve(32'h40, 1'b1, 32'h80); step();
      check_eq("empty_pop_err",   32'(err), 32'd1);
      check_eq("empty_pop_flush", 32'(flush), 32'd0);
      check_eq("empty_pop_upd",   32'(upd_valid), 32'd0);
      do_reset();

      // Predicted not-taken, actually taken.
      push(32'h44, 1'b0, 32'h0); step();
      resolve(32'h44, 1'b1, 32'h20); step();
      check_eq("nt_t_flush", 32'(flush), 32'd1);
      check_eq("nt_t_redir", redirect_pc, 32'h20);
      check_eq("nt_t_upd",   32'(upd_valid), 32'd1);
      check_eq("nt_t_idx",   32'(upd_index), 32'd1);
      check_eq("nt_t_tag",   32'(upd_tag), 32'd2);
      check_eq("nt_t_tgt",   32'(upd_target), 32'h08);
      check_eq("nt_t_state", 32'(dbg_state), 32'(ST_RECOVER));
      step();
      check_eq("nt_t_pulse_flush", 32'(flush), 32'd0);
      check_eq("nt_t_pulse_upd",   32'(upd_valid), 32'd0);
      check_eq("nt_t_run",         32'(dbg_state), 32'(ST_RUN));
      check_eq("nt_t_err",         32'(err), 32'd0);

      // Predicted taken, actually not taken; wrong-path pushes dropped.
      push(32'h48, 1'b1, 32'h90); step();
      resolve(32'h48, 1'b0, 32'h0); push(32'h100, 1'b0, 32'h0); step();
      check_eq("t_nt_flush", 32'(flush), 32'd1);
      check_eq("t_nt_redir", redirect_pc, 32'h4C);
      check_eq("t_nt_upd",   32'(upd_valid), 32'd0);
      push(32'h200, 1'b0, 32'h0); step();
      check_eq("t_nt_recover_flush", 32'(flush), 32'd0);

      // Fill to four; an accepted wrong-path push would fill it early.
      for (int i = 0; i < 3; i++) begin
         push(32'h300 + 32'(i * 4), 1'b0, 32'h0); step();
      end
      check_eq("three_full", 32'(pq_full), 32'd0);
      push(32'h30C, 1'b0, 32'h0); step();
      check_eq("four_full", 32'(pq_full), 32'd1);
      resolve(32'h300, 1'b0, 32'h0); push(32'h310, 1'b1, 32'h500); step();
      check_eq("pushpop_full",  32'(pq_full), 32'd1);
      check_eq("pushpop_flush", 32'(flush), 32'd0);
      check_eq("pushpop_err",   32'(err), 32'd0);
      push(32'h314, 1'b0, 32'h0); step();
      check_eq("overflow_err",  32'(err), 32'd1);
      check_eq("overflow_full", 32'(pq_full), 32'd1);
      resolve(32'h304, 1'b0, 32'h0); step();
      check_eq("drain_full", 32'(pq_full), 32'd0);
      resolve(32'h308, 1'b0, 32'h0); step();
      resolve(32'h30C, 1'b0, 32'h0); step();
      resolve(32'h310, 1'b0, 32'h0); step();
      check_eq("fullpush_kept_flush", 32'(flush), 32'd1);
      check_eq("fullpush_kept_redir", redirect_pc, 32'h314);
      do_reset();

      // Fall-through address wraps at 2^32; target-only mismatch.
      push(32'hFFFF_FFFC, 1'b1, 32'h10); step();
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0); step();
      check_eq("wrap_flush", 32'(flush), 32'd1);
      check_eq("wrap_redir", redirect_pc, 32'h0);
      step();
      push(32'h40, 1'b1, 32'h80); step();
      resolve(32'h40, 1'b1, 32'h84); step();
      check_eq("tgt_flush", 32'(flush), 32'd1);
      check_eq("tgt_redir", redirect_pc, 32'h84);
      check_eq("tgt_upd",   32'(upd_valid), 32'd1);
      check_eq("tgt_idx",   32'(upd_index), 32'd0);
      check_eq("tgt_tag",   32'(upd_tag), 32'd2);
      check_eq("tgt_tgt",   32'(upd_target), 32'h21);
      step();
      // Wrong head PC flags err but still compares (correct prediction).
      push(32'h90, 1'b1, 32'hA0); step();
      resolve(32'h94, 1'b1, 32'hA0); step();
      check_eq("pcmis_err",   32'(err), 32'd1);
      check_eq("pcmis_flush", 32'(flush), 32'd0);
      do_reset();

      // Stalled push and resolve must have no effect at all.
      memory_stall = 1'b1;
      push(32'h70, 1'b0, 32'h0); step();
      resolve(32'h60, 1'b1, 32'h24); step();
      check_eq("stall_flush", 32'(flush), 32'd0);
      check_eq("stall_upd",   32'(upd_valid), 32'd0);
      check_eq("stall_err",   32'(err), 32'd0);
      memory_stall = 1'b0;
      push(32'h60, 1'b0, 32'h0); step();
      resolve(32'h60, 1'b1, 32'h24); step();
      check_eq("post_stall_flush", 32'(flush), 32'd1);
      check_eq("post_stall_redir", redirect_pc, 32'h24);
      check_eq("post_stall_upd",   32'(upd_valid), 32'd1);
      check_eq("post_stall_idx",   32'(upd_index), 32'd0);
      check_eq("post_stall_tag",   32'(upd_tag), 32'd3);
      check_eq("post_stall_tgt",   32'(upd_target), 32'h09);
      check_eq("post_stall_err",   32'(err), 32'd0);

      // Reset during RECOVER with coincident resolve and push.
      check_eq("pre_rst_state", 32'(dbg_state), 32'(ST_RECOVER));
      rst = 1'b1;
      resolve(32'h44, 1'b1, 32'h20); push(32'h50, 1'b0, 32'h0); step();
      rst = 1'b0;
      check_all_zero("rst_recover");
      push(32'h80, 1'b1, 32'h100); step();
      resolve(32'h80, 1'b1, 32'h100); step();
      check_eq("post_rst_flush", 32'(flush), 32'd0);
      check_eq("post_rst_err",   32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
